// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared TMDS definitions used by the receive-side word aligner and by the
// transmit-side encoder: the four control-period tokens, the aligner FSM
// state encoding and small helpers for token decode/encode and bit-offset
// stepping.
// -----------------------------------------------------------------------------
package tmds_pkg;

   // Control tokens, indexed by {C1,C0}.
   localparam logic [9:0] TOK_CTRL0 = 10'h354;   // {C1,C0} = 00
   localparam logic [9:0] TOK_CTRL1 = 10'h0AB;   // {C1,C0} = 01
   localparam logic [9:0] TOK_CTRL2 = 10'h154;   // {C1,C0} = 10
   localparam logic [9:0] TOK_CTRL3 = 10'h2AB;   // {C1,C0} = 11

   // Highest legal bit offset within the 10-bit word.
   localparam logic [3:0] OFFSET_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } tmds_state_e;

   typedef struct packed {
      logic       valid;
      logic [1:0] ctrl;
   } tmds_tok_t;

   // Classify a word: valid=1 with its {C1,C0} when it is a control token,
   // otherwise valid=0 and ctrl=00.
   function automatic tmds_tok_t tmds_token_decode(input logic [9:0] word);
      tmds_tok_t t;
      t.valid = 1'b0;
      t.ctrl  = 2'b00;
      case (word)
         TOK_CTRL0: begin t.valid = 1'b1; t.ctrl = 2'b00; end
         TOK_CTRL1: begin t.valid = 1'b1; t.ctrl = 2'b01; end
         TOK_CTRL2: begin t.valid = 1'b1; t.ctrl = 2'b10; end
         TOK_CTRL3: begin t.valid = 1'b1; t.ctrl = 2'b11; end
         default:   begin t.valid = 1'b0; t.ctrl = 2'b00; end
      endcase
      return t;
   endfunction

   // Control-period token for a given {C1,C0} (transmit side).
   function automatic logic [9:0] tmds_ctrl_token(input logic [1:0] ctrl);
      logic [9:0] w;
      case (ctrl)
         2'b00:   w = TOK_CTRL0;
         2'b01:   w = TOK_CTRL1;
         2'b10:   w = TOK_CTRL2;
         2'b11:   w = TOK_CTRL3;
         default: w = TOK_CTRL0;
      endcase
      return w;
   endfunction

   // Step the bit offset modulo 10.
   function automatic logic [3:0] tmds_next_offset(input logic [3:0] offset);
      logic [3:0] nx;
      if (offset >= OFFSET_MAX) begin
         nx = 4'd0;
      end else begin
         nx = offset + 4'd1;
      end
      return nx;
   endfunction

endpackage

// File: rtl/tmds_word_aligner_if.sv
// -----------------------------------------------------------------------------
// tmds_word_aligner_if
// Data-path bundle of the TMDS word aligner.
//   i_data   [9:0] unaligned deserializer word, bit 0 earliest on the wire
//   o_data   [9:0] aligned TMDS word
//   o_token        o_data is a control token
//   o_ctrl   [1:0] decoded {C1,C0} when o_token=1, else 00
//   o_locked       alignment locked
//   o_offset [3:0] current bit offset, 0..9
// slave  = aligner side, master = deserializer/sink side.
// -----------------------------------------------------------------------------
interface tmds_word_aligner_if;
   logic [9:0] i_data;
   logic [9:0] o_data;
   logic       o_token;
   logic [1:0] o_ctrl;
   logic       o_locked;
   logic [3:0] o_offset;

   modport slave (
      input  i_data,
      output o_data,
      output o_token,
      output o_ctrl,
      output o_locked,
      output o_offset
   );

   modport master (
      output i_data,
      input  o_data,
      input  o_token,
      input  o_ctrl,
      input  o_locked,
      input  o_offset
   );
endinterface

// File: rtl/tmds_bit_shifter.sv
// -----------------------------------------------------------------------------
// tmds_bit_shifter
// Combinational 20-to-10 extraction: o_word = i_window[i_offset+9 : i_offset].
//   i_window [19:0] two consecutive deserializer words, bit 0 earliest
//   i_offset [3:0]  bit offset, 0..9
//   o_word   [9:0]  extracted word
// -----------------------------------------------------------------------------
module tmds_bit_shifter (
   input  logic [19:0] i_window,
   input  logic [3:0]  i_offset,
   output logic [9:0]  o_word
);

   // Select the 10-bit slice starting at the requested offset.
   always_comb begin
      o_word = i_window[9:0];
      case (i_offset)
         4'd0:    o_word = i_window[9:0];
         4'd1:    o_word = i_window[10:1];
         4'd2:    o_word = i_window[11:2];
         4'd3:    o_word = i_window[12:3];
         4'd4:    o_word = i_window[13:4];
         4'd5:    o_word = i_window[14:5];
         4'd6:    o_word = i_window[15:6];
         4'd7:    o_word = i_window[16:7];
         4'd8:    o_word = i_window[17:8];
         4'd9:    o_word = i_window[18:9];
         // Offsets above 9 are never produced; the natural continuation
         // (offset 10 = the newest whole word) is used as the safe value.
         default: o_word = i_window[19:10];
      endcase
   end

endmodule

// File: rtl/tmds_word_aligner.sv
// -----------------------------------------------------------------------------
// tmds_word_aligner
// Finds the 10-bit word boundary in a 1:10 deserialized TMDS lane by hunting
// for control tokens, one bit offset at a time.
//   i_clk           parallel (pixel) clock
//   i_rst           asynchronous, active-high reset
//   bus (slave)     i_data in; o_data, o_token, o_ctrl, o_locked, o_offset out
// Parameters:
//   SEARCH_WINDOW   cycles spent at one offset without a token before stepping
//   LOCK_RUN        consecutive tokens needed to declare lock (>= 2)
//   LOSS_WINDOW     token-free cycles tolerated while locked
// Latency i_data -> o_data is 2 cycles at offset 0.
// -----------------------------------------------------------------------------
module tmds_word_aligner
   import tmds_pkg::*;
#(
   parameter int SEARCH_WINDOW = 4096,
   parameter int LOCK_RUN      = 16,
   parameter int LOSS_WINDOW   = 1048576
) (
   input  logic               i_clk,
   input  logic               i_rst,
   tmds_word_aligner_if.slave bus
);

   localparam int TW = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
   localparam int RW = (LOCK_RUN      > 1) ? $clog2(LOCK_RUN)      : 1;
   localparam int LW = (LOSS_WINDOW   > 1) ? $clog2(LOSS_WINDOW)   : 1;

   localparam logic [TW-1:0] TIMER_LAST = TW'(SEARCH_WINDOW - 1);
   localparam logic [RW-1:0] RUN_LAST   = RW'(LOCK_RUN - 1);
   localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_WINDOW - 1);

   logic [9:0]    prev_r;
   logic [19:0]   window_s;
   logic [9:0]    aligned_s;
   tmds_tok_t     tok_s;

   tmds_state_e   state_r,  state_nx_s;
   logic [3:0]    offset_r, offset_nx_s;
   logic [TW-1:0] timer_r,  timer_nx_s;
   logic [RW-1:0] run_r,    run_nx_s;
   logic [LW-1:0] loss_r,   loss_nx_s;

   logic [9:0]    data_r;
   logic          token_r;
   logic [1:0]    ctrl_r;
   logic          locked_r;

   // Window W = {current, previous}; W[0] is the earliest bit.
   assign window_s = {bus.i_data, prev_r};

   tmds_bit_shifter u_shifter (
      .i_window (window_s),
      .i_offset (offset_r),
      .o_word   (aligned_s)
   );

   assign tok_s = tmds_token_decode(aligned_s);

   // Alignment FSM: next state, offset and counter values.
   always_comb begin
      state_nx_s  = state_r;
      offset_nx_s = offset_r;
      timer_nx_s  = timer_r;
      run_nx_s    = run_r;
      loss_nx_s   = loss_r;
      case (state_r)
         ST_SEARCH: begin
            if (tok_s.valid) begin
               state_nx_s = ST_VERIFY;
               run_nx_s   = RW'(1'b1);
               timer_nx_s = {TW{1'b0}};
            end else if (timer_r == TIMER_LAST) begin
               offset_nx_s = tmds_next_offset(offset_r);
               timer_nx_s  = {TW{1'b0}};
            end else begin
               timer_nx_s = timer_r + TW'(1'b1);
            end
         end
         ST_VERIFY: begin
            if (tok_s.valid) begin
               if (run_r == RUN_LAST) begin
                  state_nx_s = ST_LOCKED;
                  run_nx_s   = {RW{1'b0}};
                  loss_nx_s  = {LW{1'b0}};
               end else begin
                  run_nx_s = run_r + RW'(1'b1);
               end
            end else begin
               // A broken run retries the same offset from a fresh window.
               state_nx_s = ST_SEARCH;
               run_nx_s   = {RW{1'b0}};
               timer_nx_s = {TW{1'b0}};
            end
         end
         ST_LOCKED: begin
            if (tok_s.valid) begin
               loss_nx_s = {LW{1'b0}};
            end else if (loss_r == LOSS_LAST) begin
               // The current offset has gone stale; resume hunting at the next one.
               state_nx_s  = ST_SEARCH;
               offset_nx_s = tmds_next_offset(offset_r);
               timer_nx_s  = {TW{1'b0}};
               loss_nx_s   = {LW{1'b0}};
            end else begin
               loss_nx_s = loss_r + LW'(1'b1);
            end
         end
         default: begin
            state_nx_s  = ST_SEARCH;
            offset_nx_s = 4'd0;
            timer_nx_s  = {TW{1'b0}};
            run_nx_s    = {RW{1'b0}};
            loss_nx_s   = {LW{1'b0}};
         end
      endcase
   end

   // State, counters, previous word and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r  <= ST_SEARCH;
         offset_r <= 4'd0;
         timer_r  <= {TW{1'b0}};
         run_r    <= {RW{1'b0}};
         loss_r   <= {LW{1'b0}};
         prev_r   <= 10'h000;
         data_r   <= 10'h000;
         token_r  <= 1'b0;
         ctrl_r   <= 2'b00;
         locked_r <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         offset_r <= offset_nx_s;
         timer_r  <= timer_nx_s;
         run_r    <= run_nx_s;
         loss_r   <= loss_nx_s;
         prev_r   <= bus.i_data;
         data_r   <= aligned_s;
         token_r  <= tok_s.valid;
         ctrl_r   <= tok_s.ctrl;
         locked_r <= (state_nx_s == ST_LOCKED);
      end
   end

   assign bus.o_data   = data_r;
   assign bus.o_token  = token_r;
   assign bus.o_ctrl   = ctrl_r;
   assign bus.o_locked = locked_r;
   assign bus.o_offset = offset_r;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// -----------------------------------------------------------------------------
// tb_tmds_word_aligner
// Directed bench for tmds_word_aligner with SEARCH_WINDOW=16, LOCK_RUN=8,
// LOSS_WINDOW=64. The serial stream is built from aligned words placed at a
// chosen bit offset k; edge numbers in comments count posedges after reset
// release (e1 is the first). A word sent for edge n is judged by the FSM at
// edge n+1 once the offset matches.
// -----------------------------------------------------------------------------
module tb_tmds_word_aligner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   tmds_word_aligner_if bus ();

   tmds_word_aligner #(
      .SEARCH_WINDOW (16),
      .LOCK_RUN      (8),
      .LOSS_WINDOW   (64)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [9:0] last_tx = 10'h000;

   typedef struct packed {
      logic [9:0] word;
      logic       tok;
      logic [1:0] ctrl;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_clear(input string name);
      chk({name, "_data"},   32'(bus.o_data),   32'h0);
      chk({name, "_token"},  32'(bus.o_token),  32'h0);
      chk({name, "_ctrl"},   32'(bus.o_ctrl),   32'h0);
      chk({name, "_locked"}, 32'(bus.o_locked), 32'h0);
      chk({name, "_offset"}, 32'(bus.o_offset), 32'h0);
   endtask

   // Drive the deserializer word carrying aligned word w at bit offset k,
   // then step one clock and settle past the edge.
   task automatic send(input logic [9:0] w, input int k);
      logic [19:0] pair;
      pair = {w, last_tx};
      pair = pair >> (10 - k);
      bus.i_data = pair[9:0];
      last_tx = w;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_data = 10'h000;
      last_tx = 10'h000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      tbl[0] = '{word: 10'h0AB, tok: 1'b1, ctrl: 2'b01};
      tbl[1] = '{word: 10'h154, tok: 1'b1, ctrl: 2'b10};
      tbl[2] = '{word: 10'h2AB, tok: 1'b1, ctrl: 2'b11};
      tbl[3] = '{word: 10'h1F0, tok: 1'b0, ctrl: 2'b00};
      tbl[4] = '{word: 10'h354, tok: 1'b1, ctrl: 2'b00};
      tbl[5] = '{word: 10'h155, tok: 1'b0, ctrl: 2'b00};
      tbl[6] = '{word: 10'h2AA, tok: 1'b0, ctrl: 2'b00};
      tbl[7] = '{word: 10'h0AB, tok: 1'b1, ctrl: 2'b01};

      // Reset with toggling input: everything stays zero.
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.i_data = (i % 2 == 0) ? 10'h2AA : 10'h155;
         @(posedge clk);
         #1;
         chk_clear("reset_idle");
      end

      // Acquire 0x354 at offset 7: offset steps every 16 cycles, lock at e120.
      do_reset();
      for (int n = 1; n <= 120; n++) begin
         send(10'h354, 7);
         if (n == 8 || n == 40 || n == 104) chk("acq_offset_step", 32'(bus.o_offset), 32'(n / 16));
         if (n == 119) chk("acq_not_yet_locked", 32'(bus.o_locked), 32'h0);
      end
      chk("acq_locked", 32'(bus.o_locked), 32'h1);
      chk("acq_offset", 32'(bus.o_offset), 32'h7);
      chk("acq_data",   32'(bus.o_data),   32'h354);
      chk("acq_token",  32'(bus.o_token),  32'h1);
      chk("acq_ctrl",   32'(bus.o_ctrl),   32'h0);

      // Token/data mix while locked: each word shows up two cycles after drive.
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].word, 7);
         if (i > 0) begin
            chk("mix_data",   32'(bus.o_data),   32'(tbl[i-1].word));
            chk("mix_token",  32'(bus.o_token),  32'(tbl[i-1].tok));
            chk("mix_ctrl",   32'(bus.o_ctrl),   32'(tbl[i-1].ctrl));
            chk("mix_locked", 32'(bus.o_locked), 32'h1);
         end
      end
      send(10'h354, 7);
      chk("mix_last_ctrl",  32'(bus.o_ctrl),  32'h1);
      chk("mix_last_token", 32'(bus.o_token), 32'h1);
      for (int i = 0; i < 40; i++) send(10'h1F0, 7);
      chk("mix_data_run_locked", 32'(bus.o_locked), 32'h1);
      chk("mix_data_run_token",  32'(bus.o_token),  32'h0);
      chk("mix_data_run_ctrl",   32'(bus.o_ctrl),   32'h0);

      // Broken run at offset 3: tokens judged e49..e53, 0x1F0 at e54,
      // tokens resume at e55 and need a full fresh run of 8 (lock at e62).
      do_reset();
      for (int n = 1; n <= 62; n++) begin
         send((n == 53) ? 10'h1F0 : 10'h354, 3);
         if (n == 53) begin
            chk("brk_run5_locked", 32'(bus.o_locked), 32'h0);
            chk("brk_run5_token",  32'(bus.o_token),  32'h1);
         end
         if (n == 54) begin
            chk("brk_offset", 32'(bus.o_offset), 32'h3);
            chk("brk_locked", 32'(bus.o_locked), 32'h0);
            chk("brk_data",   32'(bus.o_data),   32'h1F0);
            chk("brk_token",  32'(bus.o_token),  32'h0);
         end
         if (n == 61) chk("brk_relock_early", 32'(bus.o_locked), 32'h0);
      end
      chk("brk_relock",        32'(bus.o_locked), 32'h1);
      chk("brk_relock_offset", 32'(bus.o_offset), 32'h3);

      // Loss and wrap: lock at offset 9 (e152), then the 64th zero word drops lock.
      do_reset();
      for (int n = 1; n <= 152; n++) send(10'h354, 9);
      chk("loss_pre_locked", 32'(bus.o_locked), 32'h1);
      chk("loss_pre_offset", 32'(bus.o_offset), 32'h9);
      for (int j = 1; j <= 64; j++) send(10'h000, 9);
      chk("loss_63_still_locked", 32'(bus.o_locked), 32'h1);
      send(10'h000, 9);
      chk("loss_unlocked", 32'(bus.o_locked), 32'h0);
      chk("loss_wrap_offset", 32'(bus.o_offset), 32'h0);

      // Async reset with run=4 at offset 2 (after e36), no clock edge needed.
      do_reset();
      for (int n = 1; n <= 36; n++) send(10'h354, 2);
      chk("arst_pre_offset", 32'(bus.o_offset), 32'h2);
      chk("arst_pre_token",  32'(bus.o_token),  32'h1);
      chk("arst_pre_locked", 32'(bus.o_locked), 32'h0);
      #2;
      rst = 1'b1;
      #1;
      chk_clear("arst_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         send(10'h354, 2);
         if (n == 8)  chk("arst_restart_off0", 32'(bus.o_offset), 32'h0);
         if (n == 24) chk("arst_restart_off1", 32'(bus.o_offset), 32'h1);
         if (n == 39) chk("arst_not_yet_locked", 32'(bus.o_locked), 32'h0);
      end
      chk("arst_relock",        32'(bus.o_locked), 32'h1);
      chk("arst_relock_offset", 32'(bus.o_offset), 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tmds_word_aligner.md
TMDS_WORD_ALIGNER -- requirements
Module: tmds_word_aligner

Interface
REQ-001 SHALL have parameter SEARCH_WINDOW, default 4096, meaning cycles spent at one bit offset without a token before advancing.
REQ-002 SHALL have parameter LOCK_RUN, default 16, meaning consecutive aligned control tokens required to declare lock.
REQ-003 SHALL have parameter LOSS_WINDOW, default 1048576, meaning token-free cycles tolerated while locked.
REQ-004 SHALL have port i_clk, input, 1 bit: parallel (pixel) clock; the block has one clock.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port i_data, input, 10 bits: unaligned word from the 1:10 deserializer; bit 0 is earliest on the wire.
REQ-007 SHALL have port o_data, output, 10 bits: aligned TMDS word.
REQ-008 SHALL have port o_token, output, 1 bit: o_data is one of the four control tokens.
REQ-009 SHALL have port o_ctrl, output, 2 bits: decoded {C1,C0} when o_token=1, else 0.
REQ-010 SHALL have port o_locked, output, 1 bit: alignment locked.
REQ-011 SHALL have port o_offset, output, 4 bits: current bit offset, range 0..9.

Function
REQ-012 SHALL register prev = i_data each cycle and form window W = {i_data, prev} (20 bits, W[0] earliest).
REQ-013 SHALL form the aligned word A = W[offset+9 : offset]; offset 0 yields prev.
REQ-014 SHALL register A into o_data; latency from i_data to o_data is 2 cycles at offset 0.
REQ-015 SHALL detect tokens on A: 0x354 -> ctrl 00, 0x0AB -> 01, 0x154 -> 10, 0x2AB -> 11; o_token and o_ctrl are registered alongside o_data.
REQ-016 SHALL implement the FSM states SEARCH, VERIFY and LOCKED.
REQ-017 SEARCH: a token on A -> VERIFY with run=1; otherwise the timer increments, and when the timer reaches SEARCH_WINDOW-1 the block advances offset, clears the timer and stays in SEARCH.
REQ-018 VERIFY: a token increments run; run reaching LOCK_RUN -> LOCKED; a non-token word -> SEARCH with the same offset and a cleared timer.
REQ-019 LOCKED: o_locked=1; any token clears the loss timer; the loss timer reaching LOSS_WINDOW-1 -> SEARCH with offset advanced and o_locked=0 next cycle.
REQ-020 SHALL advance offset modulo 10 (9 -> 0) and never hold a value above 9.
REQ-021 SHALL apply an offset change to A from the next cycle; words in flight are not flagged.
REQ-022 SHALL size counter widths with $clog2 of their parameter; counters SHALL saturate-free wrap never occur (cleared on every transition).

Reset
REQ-023 On i_rst the block SHALL immediately clear o_data, o_token, o_ctrl, o_locked, o_offset, prev, all counters, and set the state to SEARCH.
REQ-024 Reset asserted mid-VERIFY or mid-LOCKED SHALL abandon progress; search restarts at offset 0 after release.

Structure
REQ-025 Token constants (0x354, 0x0AB, 0x154, 0x2AB) and FSM state encodings SHALL live in shared package tmds_pkg, also used by the transmit-side encoder.
REQ-026 The 20-to-10 window extraction SHALL be sub-module tmds_bit_shifter (combinational, 4-bit offset input).

Verification (bench parameters SEARCH_WINDOW=16, LOCK_RUN=8, LOSS_WINDOW=64)
REQ-027 Reset/idle: assert i_rst with i_data toggling -> all outputs 0, o_offset=0 throughout reset.
REQ-028 Acquire: continuous 0x354 serial stream with word boundary at offset 7 -> offset steps 0..7 every 16 cycles, o_locked=1 after 8 tokens, o_data=0x354, o_ctrl=00.
REQ-029 Broken run: 5 aligned tokens, then 0x1F0 -> return to SEARCH, o_offset unchanged, o_locked stays 0.
REQ-030 Loss and wrap: locked at offset 9, then 64 cycles of 0x000 -> o_locked=0, o_offset=0.
REQ-031 Token mix: locked stream of 0x0AB, 0x154, 0x2AB -> o_ctrl 01, 10, 11 two cycles later; data words give o_token=0 and o_ctrl=00 with no lock loss under 64 cycles.
REQ-032 Async reset mid-VERIFY (run=4) -> outputs clear without a clock edge; after release the search restarts at offset 0.
